// File: rtl/qpd_sweep_scheduler.sv
// Steps the quarter-period delay trigger unit through a programmed sweep of delays,
// arming it once per repetition and collecting the returned trigger (with timeout).
module qpd_sweep_scheduler #(
  parameter int          DELAY_W        = 32,
  parameter int          STEP_W         = 8,
  parameter int          REP_W          = 8,
  parameter int unsigned MIN_DELAY      = 23000,
  parameter int          TIMEOUT_CYCLES = 200000,
  parameter int          GAP_CYCLES     = 16
) (
  input  logic               sclock,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] cfg_start_delay,
  input  logic [DELAY_W-1:0] cfg_step_delay,
  input  logic [STEP_W-1:0]  cfg_num_steps,
  input  logic [REP_W-1:0]   cfg_reps,
  input  logic               trig_in,
  output logic [DELAY_W-1:0] delay_count,
  output logic               arm,
  output logic               capture_strobe,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [STEP_W-1:0]  step_idx,
  output logic [REP_W-1:0]   rep_idx
);

  localparam int WW = DELAY_W + STEP_W;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT_TRIG, GAP, DONE} state_t;

  state_t             state;
  logic [DELAY_W-1:0] start_delay_q;
  logic [DELAY_W-1:0] step_delay_q;
  logic [STEP_W-1:0]  num_steps_q;
  logic [REP_W-1:0]   reps_q;
  logic [TW-1:0]      tmo_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [WW-1:0]      wide_sum;
  logic [DELAY_W-1:0] load_value;

  // Wide enough that start + step_idx*step never wraps; anything above DELAY_W saturates.
  always_comb begin
    wide_sum = WW'(start_delay_q) + WW'(step_idx) * WW'(step_delay_q);
    if (|wide_sum[WW-1:DELAY_W])
      load_value = '1;
    else if (wide_sum[DELAY_W-1:0] < DELAY_W'(MIN_DELAY))
      load_value = DELAY_W'(MIN_DELAY);
    else
      load_value = wide_sum[DELAY_W-1:0];
  end

  always_ff @(posedge sclock) begin
    if (rst) begin
      state          <= IDLE;
      start_delay_q  <= '0;
      step_delay_q   <= '0;
      num_steps_q    <= '0;
      reps_q         <= '0;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
      delay_count    <= '0;
      arm            <= 1'b0;
      capture_strobe <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      step_idx       <= '0;
      rep_idx        <= '0;
    end else begin
      arm            <= 1'b0;
      capture_strobe <= 1'b0;
      done           <= 1'b0;
      // Abort leaves delay/indices/error visible so software can see where the sweep stopped.
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              start_delay_q <= cfg_start_delay;
              step_delay_q  <= cfg_step_delay;
              num_steps_q   <= cfg_num_steps;
              reps_q        <= (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
              timeout_err   <= 1'b0;
              step_idx      <= '0;
              rep_idx       <= '0;
              busy          <= 1'b1;
              if (cfg_num_steps == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
          LOAD: begin
            delay_count <= load_value;
            arm         <= 1'b1;
            state       <= ARM;
          end
          ARM: begin
            tmo_cnt <= '0;
            state   <= WAIT_TRIG;
          end
          WAIT_TRIG: begin
            if (trig_in) begin
              capture_strobe <= 1'b1;
              gap_cnt        <= '0;
              state          <= GAP;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              timeout_err <= 1'b1;
              gap_cnt     <= '0;
              state       <= GAP;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              if (rep_idx < reps_q - REP_W'(1)) begin
                rep_idx <= rep_idx + REP_W'(1);
                arm     <= 1'b1;
                state   <= ARM;
              end else if (step_idx < num_steps_q - STEP_W'(1)) begin
                rep_idx  <= '0;
                step_idx <= step_idx + STEP_W'(1);
                state    <= LOAD;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qpd_sweep_scheduler.sv
// Bench for qpd_sweep_scheduler: table of whole sweeps checked against a delay model,
// plus hand sequences for latency, exact timeout, abort and reset.
module tb_qpd_sweep_scheduler;

  localparam int          DW    = 32;
  localparam int          SW    = 8;
  localparam int          RW    = 8;
  localparam int unsigned MIN_D = 23000;
  localparam int          TMO   = 50;
  localparam int          GAPC  = 4;

  logic          sclock, rst, start, abort;
  logic [DW-1:0] cfg_start_delay, cfg_step_delay;
  logic [SW-1:0] cfg_num_steps;
  logic [RW-1:0] cfg_reps;
  logic          trig_in, model_trig, man_trig;
  logic [DW-1:0] delay_count;
  logic          arm, capture_strobe, busy, done, timeout_err;
  logic [SW-1:0] step_idx;
  logic [RW-1:0] rep_idx;

  assign trig_in = model_trig | man_trig;

  qpd_sweep_scheduler #(
    .DELAY_W(DW), .STEP_W(SW), .REP_W(RW), .MIN_DELAY(MIN_D),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAPC)
  ) dut (
    .sclock(sclock), .rst(rst), .start(start), .abort(abort),
    .cfg_start_delay(cfg_start_delay), .cfg_step_delay(cfg_step_delay),
    .cfg_num_steps(cfg_num_steps), .cfg_reps(cfg_reps), .trig_in(trig_in),
    .delay_count(delay_count), .arm(arm), .capture_strobe(capture_strobe),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .step_idx(step_idx), .rep_idx(rep_idx)
  );

  typedef struct {
    logic [31:0] start_d;
    logic [31:0] step_d;
    logic [7:0]  steps;
    logic [7:0]  reps;
    int          skip;
    bit          disturb;
    int          exp_arms;
    int          exp_strobes;
    bit          exp_terr;
    int          exp_step;
    int          exp_rep;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          arm_cnt = 0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] arm_delay [512];
  int          arm_step [512];
  int          arm_rep [512];
  bit          model_enable;
  int          model_skip;

  initial begin
    sclock = 1'b0;
    forever #5 sclock = ~sclock;
  end

  // Delay-unit stand-in: returns trig_in 5 cycles after each arm unless that step is skipped.
  initial begin
    int cnt;
    cnt = 0;
    model_trig = 1'b0;
    forever begin
      @(negedge sclock);
      model_trig = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) model_trig = 1'b1;
      end
      if (arm === 1'b1 && model_enable && int'(step_idx) != model_skip) cnt = 5;
    end
  end

  initial begin
    forever begin
      @(negedge sclock);
      if (arm === 1'b1) begin
        arm_delay[arm_cnt % 512] = delay_count;
        arm_step[arm_cnt % 512]  = int'(step_idx);
        arm_rep[arm_cnt % 512]   = int'(rep_idx);
        arm_cnt++;
      end
      if (capture_strobe === 1'b1) strobe_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  function automatic logic [31:0] model_delay(input logic [31:0] s, input logic [31:0] d,
                                              input int idx);
    longint unsigned v;
    v = 64'(s) + 64'(idx) * 64'(d);
    if (v > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    if (v < 64'(MIN_D)) return MIN_D;
    return v[31:0];
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sclock);
  endtask

  task automatic start_sweep(input logic [31:0] sd, input logic [31:0] stp,
                             input logic [7:0] ns, input logic [7:0] rp);
    cfg_start_delay = sd;
    cfg_step_delay  = stp;
    cfg_num_steps   = ns;
    cfg_reps        = rp;
    start = 1'b1;
    @(negedge sclock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy !== 1'b0 && g < 5000) begin
      @(negedge sclock);
      g++;
    end
    check_output({name, "_idle"}, 64'(busy === 1'b0), 64'd1);
    @(negedge sclock);
  endtask

  task automatic wait_arm(input string name, input int stp);
    int g = 0;
    while (!(arm === 1'b1 && int'(step_idx) == stp) && g < 5000) begin
      @(negedge sclock);
      g++;
    end
    check_output({name, "_arm_seen"}, 64'(arm === 1'b1), 64'd1);
  endtask

  task automatic wait_strobe(input string name, input int stp);
    int g = 0;
    while (!(capture_strobe === 1'b1 && int'(step_idx) == stp) && g < 5000) begin
      @(negedge sclock);
      g++;
    end
    check_output({name, "_strobe_seen"}, 64'(capture_strobe === 1'b1), 64'd1);
  endtask

  task automatic apply_stimulus(input vec_t v, output int b_arm, output int b_strobe,
                                output int b_done);
    int g;
    b_arm    = arm_cnt;
    b_strobe = strobe_cnt;
    b_done   = done_cnt;
    model_skip = v.skip;
    start_sweep(v.start_d, v.step_d, v.steps, v.reps);
    g = 0;
    while (done_cnt == b_done && g < 5000) begin
      if (v.disturb && g == 8) begin
        start = 1'b1;
        cfg_start_delay = 32'd50000;
      end
      if (g == 9) start = 1'b0;
      @(negedge sclock);
      g++;
    end
    start = 1'b0;
    check_output("done_within_budget", 64'(g < 5000), 64'd1);
    tick(2);
    model_skip = -1;
  endtask

  task automatic check_vector(input int i, input vec_t v, input int b_arm, input int b_strobe,
                              input int b_done);
    int n_arms, reps_eff, idx;
    n_arms   = arm_cnt - b_arm;
    reps_eff = (v.reps == 0) ? 1 : int'(v.reps);
    check_output($sformatf("v%0d_arms", i), 64'(n_arms), 64'(v.exp_arms));
    check_output($sformatf("v%0d_strobes", i), 64'(strobe_cnt - b_strobe), 64'(v.exp_strobes));
    check_output($sformatf("v%0d_dones", i), 64'(done_cnt - b_done), 64'd1);
    check_output($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
    check_output($sformatf("v%0d_terr", i), 64'(timeout_err), 64'(v.exp_terr));
    check_output($sformatf("v%0d_step_idx", i), 64'(step_idx), 64'(v.exp_step));
    check_output($sformatf("v%0d_rep_idx", i), 64'(rep_idx), 64'(v.exp_rep));
    for (int k = 0; k < n_arms && k < v.exp_arms; k++) begin
      idx = (b_arm + k) % 512;
      check_output($sformatf("v%0d_arm%0d_delay", i, k), 64'(arm_delay[idx]),
                   64'(model_delay(v.start_d, v.step_d, k / reps_eff)));
      check_output($sformatf("v%0d_arm%0d_step", i, k), 64'(arm_step[idx]), 64'(k / reps_eff));
      check_output($sformatf("v%0d_arm%0d_rep", i, k), 64'(arm_rep[idx]), 64'(k % reps_eff));
    end
    if (v.exp_arms > 0) begin
      check_output($sformatf("v%0d_first_delay", i), 64'(arm_delay[b_arm % 512]),
                   64'(v.exp_first));
      check_output($sformatf("v%0d_last_delay", i), 64'(arm_delay[(arm_cnt + 511) % 512]),
                   64'(v.exp_last));
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   ba, bs, bd, base_done;

    vecs[0] = '{32'd23000, 32'd100, 8'd3, 8'd1, -1, 1'b0, 3, 3, 1'b0, 2, 0, 32'd23000, 32'd23200};
    vecs[1] = '{32'd10, 32'd0, 8'd1, 8'd1, -1, 1'b0, 1, 1, 1'b0, 0, 0, 32'd23000, 32'd23000};
    vecs[2] = '{32'hFFFF_FF00, 32'h200, 8'd2, 8'd1, -1, 1'b0, 2, 2, 1'b0, 1, 0,
                32'hFFFF_FF00, 32'hFFFF_FFFF};
    vecs[3] = '{32'd5000, 32'd30000, 8'd2, 8'd3, -1, 1'b0, 6, 6, 1'b0, 1, 2, 32'd23000, 32'd35000};
    vecs[4] = '{32'd24000, 32'd1000, 8'd2, 8'd0, -1, 1'b0, 2, 2, 1'b0, 1, 0, 32'd24000, 32'd25000};
    vecs[5] = '{32'd23000, 32'd100, 8'd3, 8'd1, 1, 1'b0, 3, 2, 1'b1, 2, 0, 32'd23000, 32'd23200};
    vecs[6] = '{32'd40000, 32'd5, 8'd0, 8'd4, -1, 1'b0, 0, 0, 1'b0, 0, 0, 32'd0, 32'd0};
    vecs[7] = '{32'd23000, 32'd100, 8'd3, 8'd1, -1, 1'b1, 3, 3, 1'b0, 2, 0, 32'd23000, 32'd23200};

    rst = 1'b1; start = 1'b0; abort = 1'b0; man_trig = 1'b0;
    cfg_start_delay = '0; cfg_step_delay = '0; cfg_num_steps = '0; cfg_reps = '0;
    model_enable = 1'b1; model_skip = -1;
    tick(3);
    check_output("rst_delay_count", 64'(delay_count), 64'd0);
    check_output("rst_arm", 64'(arm), 64'd0);
    check_output("rst_strobe", 64'(capture_strobe), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_terr", 64'(timeout_err), 64'd0);
    check_output("rst_step_idx", 64'(step_idx), 64'd0);
    check_output("rst_rep_idx", 64'(rep_idx), 64'd0);
    rst = 1'b0;
    tick(1);

    // Start-to-arm latency: busy one cycle after start, arm and delay the cycle after.
    start_sweep(32'd30000, 32'd0, 8'd1, 8'd1);
    check_output("lat_busy_t1", 64'(busy), 64'd1);
    check_output("lat_arm_t1", 64'(arm), 64'd0);
    tick(1);
    check_output("lat_arm_t2", 64'(arm), 64'd1);
    check_output("lat_delay_t2", 64'(delay_count), 64'd30000);
    wait_idle("lat");

    // Empty sweep goes straight to DONE.
    ba = arm_cnt;
    start_sweep(32'd40000, 32'd0, 8'd0, 8'd1);
    check_output("empty_done_t1", 64'(done), 64'd1);
    check_output("empty_busy_t1", 64'(busy), 64'd1);
    tick(1);
    check_output("empty_done_t2", 64'(done), 64'd0);
    check_output("empty_busy_t2", 64'(busy), 64'd0);
    check_output("empty_no_arm", 64'(arm_cnt - ba), 64'd0);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i], ba, bs, bd);
      check_vector(i, vecs[i], ba, bs, bd);
    end

    // Trigger on the last WAIT_TRIG cycle beats the timeout.
    model_enable = 1'b0;
    start_sweep(32'd30000, 32'd0, 8'd1, 8'd1);
    wait_arm("tmo_edge", 0);
    tick(TMO);
    man_trig = 1'b1;
    tick(1);
    man_trig = 1'b0;
    check_output("tmo_edge_strobe", 64'(capture_strobe), 64'd1);
    check_output("tmo_edge_terr", 64'(timeout_err), 64'd0);
    wait_idle("tmo_edge");

    // One cycle later the repetition has already timed out; trig_in in GAP is ignored.
    start_sweep(32'd30000, 32'd0, 8'd1, 8'd1);
    wait_arm("tmo_late", 0);
    tick(TMO);
    check_output("tmo_not_early", 64'(timeout_err), 64'd0);
    tick(1);
    man_trig = 1'b1;
    tick(1);
    man_trig = 1'b0;
    check_output("gap_trig_no_strobe", 64'(capture_strobe), 64'd0);
    check_output("tmo_late_terr", 64'(timeout_err), 64'd1);
    wait_idle("tmo_late");
    model_enable = 1'b1;

    // Abort while waiting on step 1, then abort colliding with start, then a clean restart.
    model_skip = 1;
    base_done = done_cnt;
    start_sweep(32'd23000, 32'd100, 8'd3, 8'd1);
    wait_arm("abort", 1);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_arm", 64'(arm), 64'd0);
    check_output("abort_step_idx", 64'(step_idx), 64'd1);
    check_output("abort_delay_held", 64'(delay_count), 64'd23100);
    tick(20);
    check_output("abort_no_done", 64'(done_cnt - base_done), 64'd0);
    check_output("abort_still_idle", 64'(busy), 64'd0);
    abort = 1'b1;
    start = 1'b1;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    check_output("abort_beats_start", 64'(busy), 64'd0);
    model_skip = -1;
    start_sweep(32'd23000, 32'd100, 8'd3, 8'd1);
    wait_arm("restart", 0);
    check_output("restart_delay", 64'(delay_count), 64'd23000);
    check_output("restart_rep_idx", 64'(rep_idx), 64'd0);
    wait_idle("restart");

    // Reset in the GAP of step 1 after step 0 timed out clears everything, no done.
    model_skip = 0;
    base_done = done_cnt;
    start_sweep(32'd23000, 32'd100, 8'd3, 8'd1);
    wait_strobe("rst_gap", 1);
    check_output("rst_gap_terr_before", 64'(timeout_err), 64'd1);
    rst = 1'b1;
    tick(1);
    check_output("rst_gap_delay", 64'(delay_count), 64'd0);
    check_output("rst_gap_step_idx", 64'(step_idx), 64'd0);
    check_output("rst_gap_busy", 64'(busy), 64'd0);
    check_output("rst_gap_terr", 64'(timeout_err), 64'd0);
    check_output("rst_gap_arm", 64'(arm), 64'd0);
    check_output("rst_gap_strobe", 64'(capture_strobe), 64'd0);
    rst = 1'b0;
    model_skip = -1;
    tick(10);
    check_output("rst_gap_no_done", 64'(done_cnt - base_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
